// File: rtl/mod997_pkg.sv
// rtl/mod997_pkg.sv - shared mod-997 residue constants and types
package mod997_pkg;

  localparam int MODULUS = 997;
  localparam int RES_W   = 10;

  typedef logic [RES_W-1:0] residue_t;

endpackage

// File: rtl/mod997_add.sv
// rtl/mod997_add.sv - combinational (a + b) mod 997 for a, b < 997
module mod997_add
  import mod997_pkg::*;
(
  input  logic [RES_W-1:0] a,
  input  logic [RES_W-1:0] b,
  output logic [RES_W-1:0] sum
);

  logic [RES_W:0] raw;

  // Both operands are below the modulus, so one conditional subtract suffices.
  always_comb begin
    raw = {1'b0, a} + {1'b0, b};
    if (raw >= (RES_W+1)'(MODULUS)) begin
      sum = RES_W'(raw - (RES_W+1)'(MODULUS));
    end else begin
      sum = raw[RES_W-1:0];
    end
  end

endmodule

// File: rtl/mod997_residue_acc.sv
// rtl/mod997_residue_acc.sv - frame accumulator of chunk residues mod 997
// Optional input range check enabled by defining MOD997_ACC_RANGE_CHECK_EN.
module mod997_residue_acc
  import mod997_pkg::*;
#(
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RES_W-1:0] in_res,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_res,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_err
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t           state;
  residue_t         acc;
  logic [CNT_W-1:0] cnt;
  logic             err;

  residue_t         term;
  logic             range_err;
  residue_t         sum;
  residue_t         acc_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             err_nxt;
  logic             cnt_full;
  logic             take;
  logic             give;

`ifdef MOD997_ACC_RANGE_CHECK_EN
  always_comb begin
    range_err = (in_res >= RES_W'(MODULUS));
    term      = range_err ? in_res - RES_W'(MODULUS) : in_res;
  end
`else
  assign range_err = 1'b0;
  assign term      = in_res;
`endif

  mod997_add u_add (
    .a   (acc),
    .b   (term),
    .sum (sum)
  );

  assign in_ready = (state != DONE);
  assign take     = in_valid && in_ready;
  assign give     = out_valid && out_ready;
  assign cnt_full = &cnt;

  // The first term of a frame replaces the accumulator rather than adding to it.
  always_comb begin
    acc_nxt = sum;
    cnt_nxt = cnt_full ? cnt : cnt + CNT_W'(1);
    err_nxt = err | range_err | cnt_full;
    if (state == IDLE) begin
      acc_nxt = term;
      cnt_nxt = CNT_W'(1);
      err_nxt = range_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      err       <= 1'b0;
      out_valid <= 1'b0;
      out_res   <= '0;
      out_cnt   <= '0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        IDLE, ACC: begin
          if (take) begin
            acc <= acc_nxt;
            cnt <= cnt_nxt;
            err <= err_nxt;
            if (in_last) begin
              state     <= DONE;
              out_valid <= 1'b1;
              out_res   <= acc_nxt;
              out_cnt   <= cnt_nxt;
              out_err   <= err_nxt;
            end else begin
              state <= ACC;
            end
          end
        end
        DONE: begin
          if (give) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
